// File: rtl/uart_frame_parser.sv
// Frame parser for the uart_rx byte stream: SOF, CMD, LEN, payload, XOR checksum.
// Holds one good frame for the consumer until it is acknowledged.
module uart_frame_parser #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 25000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_frame_valid,
    input  logic              i_frame_ack,
    output logic [7:0]        o_frame_cmd,
    output logic [7:0]        o_frame_len,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_busy,
    output logic              o_err_chk,
    output logic              o_err_len,
    output logic              o_err_timeout,
    output logic              o_err_overrun
);
    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_CMD, S_GET_LEN, S_GET_PAY, S_GET_CHK, S_HOLD
    } state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_cmd_sh, w_cmd_sh_next;
    logic [7:0]        r_len_sh, w_len_sh_next;
    logic [7:0]        r_chk, w_chk_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic [7:0]        r_frame_cmd, w_frame_cmd_next;
    logic [7:0]        r_frame_len, w_frame_len_next;
    logic              r_frame_valid, w_frame_valid_next;
    logic              r_err_chk, w_err_chk_next;
    logic              r_err_len, w_err_len_next;
    logic              r_err_timeout, w_err_timeout_next;
    logic              r_err_overrun, w_err_overrun_next;
    logic [TW-1:0]     r_tcnt, w_tcnt_next;
    logic              w_buf_we;

    logic [7:0] r_buf [0:(2**ADDR_W)-1];

    always_comb begin
        w_state_next       = r_state;
        w_cmd_sh_next      = r_cmd_sh;
        w_len_sh_next      = r_len_sh;
        w_chk_next         = r_chk;
        w_idx_next         = r_idx;
        w_frame_cmd_next   = r_frame_cmd;
        w_frame_len_next   = r_frame_len;
        w_frame_valid_next = r_frame_valid;
        w_err_chk_next     = 1'b0;
        w_err_len_next     = 1'b0;
        w_err_timeout_next = 1'b0;
        w_err_overrun_next = 1'b0;
        w_tcnt_next        = '0;
        w_buf_we           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == SOF_BYTE) begin
                    w_chk_next   = 8'h00;
                    w_state_next = S_GET_CMD;
                end
            end
            S_GET_CMD: begin
                if (i_rx_valid) begin
                    w_cmd_sh_next = i_rx_data;
                    w_chk_next    = r_chk ^ i_rx_data;
                    w_state_next  = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (i_rx_valid) begin
                    w_len_sh_next = i_rx_data;
                    w_chk_next    = r_chk ^ i_rx_data;
                    if (i_rx_data > 8'(MAX_LEN)) begin
                        w_err_len_next = 1'b1;
                        w_state_next   = S_IDLE;
                    end else if (i_rx_data == 8'h00) begin
                        w_state_next = S_GET_CHK;
                    end else begin
                        w_idx_next   = '0;
                        w_state_next = S_GET_PAY;
                    end
                end
            end
            S_GET_PAY: begin
                if (i_rx_valid) begin
                    w_buf_we   = 1'b1;
                    w_chk_next = r_chk ^ i_rx_data;
                    w_idx_next = r_idx + 1'b1;
                    if (8'(r_idx) == r_len_sh - 8'd1)
                        w_state_next = S_GET_CHK;
                end
            end
            S_GET_CHK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == r_chk) begin
                        w_frame_cmd_next   = r_cmd_sh;
                        w_frame_len_next   = r_len_sh;
                        w_frame_valid_next = 1'b1;
                        w_state_next       = S_HOLD;
                    end else begin
                        w_err_chk_next = 1'b1;
                        w_state_next   = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // A byte arriving while a frame is held is always dropped, even alongside ack.
                w_err_overrun_next = i_rx_valid;
                if (i_frame_ack) begin
                    w_frame_valid_next = 1'b0;
                    w_state_next       = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (r_state != S_IDLE && r_state != S_HOLD && !i_rx_valid) begin
            if (r_tcnt == T_LAST) begin
                w_err_timeout_next = 1'b1;
                w_state_next       = S_IDLE;
            end else begin
                w_tcnt_next = r_tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cmd_sh      <= 8'h00;
            r_len_sh      <= 8'h00;
            r_chk         <= 8'h00;
            r_idx         <= '0;
            r_frame_cmd   <= 8'h00;
            r_frame_len   <= 8'h00;
            r_frame_valid <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cmd_sh      <= w_cmd_sh_next;
            r_len_sh      <= w_len_sh_next;
            r_chk         <= w_chk_next;
            r_idx         <= w_idx_next;
            r_frame_cmd   <= w_frame_cmd_next;
            r_frame_len   <= w_frame_len_next;
            r_frame_valid <= w_frame_valid_next;
            r_err_chk     <= w_err_chk_next;
            r_err_len     <= w_err_len_next;
            r_err_timeout <= w_err_timeout_next;
            r_err_overrun <= w_err_overrun_next;
            r_tcnt        <= w_tcnt_next;
        end
    end

    // Payload buffer is not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_buf_we)
            r_buf[r_idx] <= i_rx_data;
    end

    assign o_rd_data     = r_buf[i_rd_addr];
    assign o_frame_valid = r_frame_valid;
    assign o_frame_cmd   = r_frame_cmd;
    assign o_frame_len   = r_frame_len;
    assign o_busy        = (r_state != S_IDLE);
    assign o_err_chk     = r_err_chk;
    assign o_err_len     = r_err_len;
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good, zero-length, bad checksum, overflow,
// timeout, async reset mid-frame and overrun/drop cases.
module tb_uart_frame_parser;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       frame_valid, busy, err_chk, err_len, err_timeout, err_overrun;
    logic [7:0] frame_cmd, frame_len, rd_data;

    int n_vec = 0;
    int n_bad = 0;

    uart_frame_parser #(
        .SOF_BYTE(8'hA5), .MAX_LEN(16), .ADDR_W(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_frame_valid(frame_valid), .i_frame_ack(frame_ack),
        .o_frame_cmd(frame_cmd), .o_frame_len(frame_len),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_busy(busy),
        .o_err_chk(err_chk), .o_err_len(err_len),
        .o_err_timeout(err_timeout), .o_err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
            $display("vec %0d %s obs=%02h exp=%02h ok", n_vec, tag, obs, exp);
        else begin
            n_bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] errs();
        return {4'b0, err_chk, err_len, err_timeout, err_overrun};
    endfunction

    // One-cycle strobe; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [7:0] good[7]  = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
    logic [7:0] zero[6]  = '{8'h00, 8'hFF, 8'hA5, 8'h7E, 8'h00, 8'h7E};
    logic [7:0] badck[7] = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14};
    logic [7:0] exp_pay[3] = '{8'h11, 8'h22, 8'h33};

    task automatic send_good();
        for (int i = 0; i < 6; i++) send_byte(good[i]);
        check("good_pre_valid", {7'b0, frame_valid}, 8'h00);
        send_byte(good[6]);
    endtask

    task automatic ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", {7'b0, frame_valid}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_cmd", frame_cmd, 8'h00);
        check("rst_errs", errs(), 8'h00);
        rst_n = 1'b1;

        // Good frame
        send_good();
        check("good_valid", {7'b0, frame_valid}, 8'h01);
        check("good_cmd", frame_cmd, 8'h10);
        check("good_len", frame_len, 8'h03);
        check("good_errs", errs(), 8'h00);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'(i);
            #1 check($sformatf("good_rd%0d", i), rd_data, exp_pay[i]);
        end
        ack();
        check("ack_valid", {7'b0, frame_valid}, 8'h00);
        check("ack_busy", {7'b0, busy}, 8'h00);

        // Junk then zero-length frame
        send_byte(zero[0]);
        send_byte(zero[1]);
        check("junk_busy", {7'b0, busy}, 8'h00);
        check("junk_errs", errs(), 8'h00);
        for (int i = 2; i < 6; i++) send_byte(zero[i]);
        check("zero_valid", {7'b0, frame_valid}, 8'h01);
        check("zero_cmd", frame_cmd, 8'h7E);
        check("zero_len", frame_len, 8'h00);
        ack();

        // Bad checksum, then a good frame
        for (int i = 0; i < 7; i++) send_byte(badck[i]);
        check("badck_errs", errs(), 8'h08);
        check("badck_valid", {7'b0, frame_valid}, 8'h00);
        check("badck_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("badck_pulse_end", errs(), 8'h00);
        send_good();
        check("after_badck_valid", {7'b0, frame_valid}, 8'h01);
        ack();

        // Length overflow, then a good frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        check("len_errs", errs(), 8'h04);
        check("len_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("len_pulse_end", errs(), 8'h00);
        send_good();
        check("after_len_valid", {7'b0, frame_valid}, 8'h01);
        check("after_len_len", frame_len, 8'h03);
        ack();

        // Inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO - 1) @(negedge clk);
        check("to_early_errs", errs(), 8'h00);
        check("to_early_busy", {7'b0, busy}, 8'h01);
        @(negedge clk);
        check("to_errs", errs(), 8'h02);
        check("to_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("to_pulse_end", errs(), 8'h00);

        // Asynchronous reset mid-frame
        send_byte(8'hA5);
        check("rstmid_busy_pre", {7'b0, busy}, 8'h01);
        #2 rst_n = 1'b0;
        #1 check("rstmid_busy", {7'b0, busy}, 8'h00);
        check("rstmid_errs", errs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Overrun while held, then byte in the same cycle as ack
        send_good();
        send_byte(8'hA5);
        check("ovr_errs", errs(), 8'h01);
        check("ovr_valid", {7'b0, frame_valid}, 8'h01);
        check("ovr_cmd", frame_cmd, 8'h10);
        check("ovr_len", frame_len, 8'h03);
        rd_addr = 4'd1;
        #1 check("ovr_rd1", rd_data, 8'h22);
        @(negedge clk);
        rx_data = 8'hA5; rx_valid = 1'b1; frame_ack = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; frame_ack = 1'b0;
        check("ovrack_errs", errs(), 8'h01);
        check("ovrack_valid", {7'b0, frame_valid}, 8'h00);
        check("ovrack_busy", {7'b0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of uart_rx and consumes its byte/done outputs.
- Assembles bytes into command frames: SOF, CMD, LEN, payload, checksum.
- Validates the frame and buffers the payload.
- Presents a complete good frame to the register/control logic with a valid/ack handshake, and flags malformed, timed-out or overrun frames.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes accepted (1..2**ADDR_W).
- ADDR_W, 4, payload buffer address width.
- TIMEOUT_CYCLES, 25000, inter-byte timeout in clk cycles (about 2 byte times at 9600 baud, 12 MHz).

Ports:
- clk  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_data  in  8  byte from uart_rx data_out.
- rx_valid  in  1  one-cycle strobe from uart_rx rx_done; rx_data is valid while high.
- frame_valid  out  1  good frame held in buffer; stays high until acked.
- frame_ack  in  1  consumer releases the frame.
- frame_cmd  out  8  CMD byte of the held frame.
- frame_len  out  8  LEN byte of the held frame.
- rd_addr  in  ADDR_W  payload read index.
- rd_data  out  8  payload byte at rd_addr (combinational read).
- busy  out  1  state is not IDLE.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_len  out  1  one-cycle pulse on LEN > MAX_LEN.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout.
- err_overrun  out  1  one-cycle pulse when a byte arrives during HOLD.

Behaviour:
- Reset:
  - Asynchronous, active-low; state forced to IDLE.
  - frame_valid, frame_cmd, frame_len, busy, all err_* and timeout counter all 0.
  - Buffer RAM is not reset.
  - Reset mid-frame discards the partial frame.
- Byte handling: only acted on in cycles with rx_valid=1. Frame wire format is SOF, CMD, LEN, LEN payload bytes, CHK.
- Checksum: 8-bit running XOR over CMD, LEN and all payload bytes; cleared to 0 on SOF acceptance.
- FSM states: IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK, HOLD.
  - IDLE: byte == SOF_BYTE -> GET_CMD. Any other byte is silently ignored, with no error.
  - GET_CMD: latch the byte into a shadow cmd, XOR it into the checksum -> GET_LEN.
  - GET_LEN:
    - If LEN > MAX_LEN: pulse err_len, go to IDLE; remaining bytes of that frame are then ignored as non-SOF bytes (an A5 in the data would resync).
    - If LEN == 0 -> GET_CHK.
    - Otherwise clear the payload index -> GET_PAY.
    - LEN is latched into a shadow len and XORed into the checksum.
  - GET_PAY: write the byte to buffer[index], XOR it, index+1. When index == len-1 -> GET_CHK.
  - GET_CHK:
    - If the byte equals the checksum: copy shadows to frame_cmd/frame_len, set frame_valid -> HOLD.
    - Otherwise pulse err_chk -> IDLE.
- Latency: frame_valid and all err_* are registered and assert on the clk edge after the rx_valid cycle of the deciding byte.
- HOLD:
  - frame_valid=1; frame_cmd, frame_len and buffer contents are stable.
  - frame_ack=1 -> frame_valid=0 next cycle, state -> IDLE.
  - Any rx_valid in HOLD, including in the same cycle as frame_ack, drops the byte and pulses err_overrun; buffer and outputs stay unchanged.
  - frame_ack outside HOLD is ignored.
- Timeout:
  - The counter clears on every rx_valid and in IDLE/HOLD.
  - In GET_CMD..GET_CHK it increments each cycle without rx_valid.
  - On reaching TIMEOUT_CYCLES-1: pulse err_timeout, go to IDLE.
  - If rx_valid arrives in the expiry cycle, the byte wins: it is processed normally and there is no timeout.
- rd_data: rd_data = buffer[rd_addr]. It is defined only in HOLD for rd_addr < frame_len; otherwise don't-care.
- busy is 1 in every state except IDLE.
- Error pulses are mutually exclusive and each lasts exactly 1 cycle.

Test Plan:
- Good frame: bytes A5 10 03 11 22 33 13 -> frame_valid=1 one cycle after the last strobe; frame_cmd=10, frame_len=03; rd_addr 0/1/2 gives 11/22/33; no err_*. Drive frame_ack -> frame_valid=0 next cycle, busy=0.
- Zero-length frame, plus junk before SOF: bytes 00 FF A5 7E 00 7E -> leading bytes ignored; frame_valid with frame_cmd=7E, frame_len=00.
- Bad checksum: A5 10 03 11 22 33 14 -> err_chk single pulse, frame_valid stays 0, back in IDLE. A following good frame is accepted.
- Length overflow: A5 01 11 -> err_len pulse after the LEN byte, busy=0. A subsequent good frame parses correctly.
- Timeout and reset mid-frame:
  - Send A5 10, then idle -> err_timeout exactly TIMEOUT_CYCLES cycles after the last strobe, busy=0.
  - Repeat, but assert reset=0 after A5 -> all outputs 0 immediately.
- Overrun and the drop rule: good frame held, no ack; send A5 -> err_overrun, frame_cmd/len/rd_data unchanged. Then send a byte in the same cycle as frame_ack -> err_overrun, frame released, byte not parsed.
- End-to-end: drive the serial line through uart_rx at 1250 clk/bit with the frame A5 10 03 11 22 33 13 -> same result as the good-frame case.
